vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator, successor to the fixed 640x480 counter-based top level.
- Produces sync pulses with programmable polarity, a display-enable signal, pixel coordinates, and line/frame strobes from one system clock.
- Includes an internal pixel-clock-enable divider, so a 50 MHz board clock drives 25 MHz pixel timing.
- Sits between the board clock and any pixel source (test pattern, framebuffer reader) that drives Red/Green/Blue.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- H_SYNC_POL, 0, active level of Hsync (0 = active-low)
- V_SYNC_POL, 0, active level of Vsync
- PIX_DIV, 2, Clk cycles per pixel (>=1)
- CNT_W, 11, width of Pix_X/Pix_Y; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- Enable  in  1  run control; low freezes all state
- Pix_Tick  out  1  one-Clk pulse marking each pixel period
- Hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- Vsync  out  1  vertical sync, polarity per V_SYNC_POL
- Display_En  out  1  high when (Pix_X, Pix_Y) lies in the visible area
- Pix_X  out  CNT_W  current horizontal position, 0..H_TOTAL-1
- Pix_Y  out  CNT_W  current vertical position, 0..V_TOTAL-1
- Line_Start  out  1  one-Clk pulse when Pix_X becomes 0
- Frame_Start  out  1  one-Clk pulse when (Pix_X, Pix_Y) becomes (0, 0)
- Frame_Count  out  8  frames started since reset, wraps 255->0

Behaviour:
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK. V_TOTAL is formed the same way from the V_ parameters.
- Line order: display [0, H_DISPLAY-1], front porch, sync, back porch. The vertical axis follows the same order.
- Divider: counts 0..PIX_DIV-1. Pix_Tick is asserted in the cycle where the divider equals PIX_DIV-1. With PIX_DIV=1, Pix_Tick is constantly high while Enable is high.
- Counter advance on Pix_Tick:
  - h advances by 1, or wraps to 0 after H_TOTAL-1.
  - When h wraps, v advances by 1, or wraps to 0 after V_TOTAL-1.
- Registered outputs: all outputs except Pix_Tick are registered and load on the Clk edge that ends a Pix_Tick cycle. They are decoded from the new (h, v), so coordinates, syncs and Display_En are mutually consistent in every cycle.
- Hsync is active while H_DISPLAY+H_FRONT <= Pix_X <= H_DISPLAY+H_FRONT+H_SYNC-1. Otherwise it sits at the inactive level (~H_SYNC_POL). Vsync is decoded the same way on Pix_Y.
- Display_En = (Pix_X < H_DISPLAY) && (Pix_Y < V_DISPLAY).
- Strobes:
  - Line_Start and Frame_Start are high for exactly one Clk, the cycle after the loading edge, and low otherwise.
  - Frame_Start implies Line_Start.
  - Frame_Count increments on the same edge that asserts Frame_Start.
- Reset values:
  - Divider = 0.
  - Internal h = H_TOTAL-1, v = V_TOTAL-1.
  - Pix_X = H_TOTAL-1, Pix_Y = V_TOTAL-1.
  - Hsync and Vsync at their inactive levels; Display_En, strobes and Pix_Tick = 0; Frame_Count = 0.
  - Consequence: the first Pix_Tick after reset wraps to (0, 0) and emits Frame_Start with Frame_Count = 1.
- Enable low: divider, counters and outputs hold their values, Pix_Tick = 0, and strobes are forced to 0. Raising Enable resumes from the held phase with no skipped or repeated pixel.
- Reset asserted mid-frame: every register returns to its reset value immediately, independent of Clk.
- Arithmetic: all comparisons are unsigned at CNT_W bits. Parameter legality (each width >= 1, H_TOTAL <= 2^CNT_W) is checked at elaboration; an illegal set is a fatal error.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 timing constants (matching the Parameters defaults);
  - a second set for 800x600@72;
  - a function computing the minimum CNT_W for a given total.
- Sub-module vga_axis_counter, instantiated twice (horizontal, vertical):
  - parameters DISPLAY, FRONT, SYNC, BACK, SYNC_POL;
  - inputs: step, plus the shared Clk and Reset;
  - outputs: count, wrap, sync, active.
- The top level holds the divider, the output registers, the strobes and Frame_Count.

Test Plan:
- Reset release, PIX_DIV=2, small timing (H 8/2/3/1 giving H_TOTAL=14; V 4/1/2/1 giving V_TOTAL=8) -> Pix_Tick every 2nd Clk; first tick gives Pix_X=0, Pix_Y=0, Frame_Start=1, Line_Start=1, Frame_Count=1, Display_En=1.
- Same config, run one line -> Display_En high for Pix_X 0..7; Hsync low (active-low) exactly for Pix_X 10..12; Pix_X wraps 13->0 with Line_Start and Pix_Y=1.
- Full frame, V_SYNC_POL=1 -> Vsync high exactly for Pix_Y 5..6; 112 ticks between Frame_Starts; Display_En never high for Pix_Y >= 4.
- PIX_DIV=1 with default 640x480 -> 800x525 = 420000 Clk between Frame_Start pulses; Frame_Count wraps 255->0 on the 256th frame.
- Enable dropped for 5 Clk at Pix_X=6 -> all outputs hold and Pix_Tick stays 0; after Enable returns, the next tick yields Pix_X=7, not 8.
- Reset asserted asynchronously at Pix_X=9, Pix_Y=2 -> outputs return to their reset values before the next Clk edge; after release, the first tick produces Frame_Start at (0, 0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - timing presets and width helper for vga_timing_gen
//
// Contents:
//   VGA640_*  : 640x480@60 timing (25 MHz pixel rate, PIX_DIV=2 from a 50 MHz clock)
//   SVGA800_* : 800x600@72 timing (50 MHz pixel rate, PIX_DIV=1 from a 50 MHz clock)
//   min_cnt_w : smallest counter width able to hold total-1

package vga_timing_pkg;

    localparam int VGA640_H_DISPLAY  = 640;
    localparam int VGA640_H_FRONT    = 16;
    localparam int VGA640_H_SYNC     = 96;
    localparam int VGA640_H_BACK     = 48;
    localparam int VGA640_V_DISPLAY  = 480;
    localparam int VGA640_V_FRONT    = 10;
    localparam int VGA640_V_SYNC     = 2;
    localparam int VGA640_V_BACK     = 33;
    localparam int VGA640_H_SYNC_POL = 0;
    localparam int VGA640_V_SYNC_POL = 0;
    localparam int VGA640_PIX_DIV    = 2;
    localparam int VGA640_CNT_W      = 11;

    localparam int SVGA800_H_DISPLAY  = 800;
    localparam int SVGA800_H_FRONT    = 56;
    localparam int SVGA800_H_SYNC     = 120;
    localparam int SVGA800_H_BACK     = 64;
    localparam int SVGA800_V_DISPLAY  = 600;
    localparam int SVGA800_V_FRONT    = 37;
    localparam int SVGA800_V_SYNC     = 6;
    localparam int SVGA800_V_BACK     = 23;
    localparam int SVGA800_H_SYNC_POL = 1;
    localparam int SVGA800_V_SYNC_POL = 1;
    localparam int SVGA800_PIX_DIV    = 1;
    localparam int SVGA800_CNT_W      = 11;

    // Width needed to represent 0..total-1; never less than one bit.
    function automatic int min_cnt_w(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with sync/active decode
//
// Ports:
//   Clk, Reset : shared clock and asynchronous active-low reset
//   step       : advance the position by one this cycle
//   count      : position the axis will hold after this cycle (next value)
//   wrap       : step is wrapping the position from TOTAL-1 back to 0
//   sync       : sync level decoded from count, polarity per SYNC_POL
//   active     : count lies in the display region
//
// The outputs describe the upcoming position so the parent can register
// coordinates and their decodes on the same edge the counter moves.

module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY  = VGA640_H_DISPLAY,
    parameter int FRONT    = VGA640_H_FRONT,
    parameter int SYNC     = VGA640_H_SYNC,
    parameter int BACK     = VGA640_H_BACK,
    parameter int SYNC_POL = VGA640_H_SYNC_POL,
    parameter int CNT_W    = VGA640_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync,
    output logic             active
);

    localparam int TOTAL = DISPLAY + FRONT + SYNC + BACK;

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(DISPLAY + FRONT);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(DISPLAY + FRONT + SYNC - 1);
    localparam logic [CNT_W-1:0] DISP_END   = CNT_W'(DISPLAY);
    localparam logic             SYNC_ON    = (SYNC_POL != 0);

    logic [CNT_W-1:0] count_q;

    assign wrap   = step && (count_q == LAST);
    assign count  = !step ? count_q : (wrap ? '0 : count_q + CNT_W'(1));
    assign sync   = ((count >= SYNC_FIRST) && (count <= SYNC_LAST)) ? SYNC_ON : ~SYNC_ON;
    assign active = (count < DISP_END);

    // Reset parks on the last position so the first step lands on 0.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= LAST;
        end else begin
            count_q <= count;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
//
// Ports:
//   Clk         : system clock, rising edge
//   Reset       : asynchronous active-low reset
//   Enable      : run control; low freezes divider, counters and outputs
//   Pix_Tick    : one-Clk pulse per pixel period (combinational)
//   Hsync/Vsync : sync pulses, polarity per H_SYNC_POL / V_SYNC_POL
//   Display_En  : (Pix_X, Pix_Y) is inside the visible area
//   Pix_X/Pix_Y : current raster position
//   Line_Start  : one-Clk pulse after Pix_X becomes 0
//   Frame_Start : one-Clk pulse after (Pix_X, Pix_Y) becomes (0, 0)
//   Frame_Count : frames started since reset, modulo 256

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY  = VGA640_H_DISPLAY,
    parameter int H_FRONT    = VGA640_H_FRONT,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BACK     = VGA640_H_BACK,
    parameter int V_DISPLAY  = VGA640_V_DISPLAY,
    parameter int V_FRONT    = VGA640_V_FRONT,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BACK     = VGA640_V_BACK,
    parameter int H_SYNC_POL = VGA640_H_SYNC_POL,
    parameter int V_SYNC_POL = VGA640_V_SYNC_POL,
    parameter int PIX_DIV    = VGA640_PIX_DIV,
    parameter int CNT_W      = VGA640_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    output logic             Pix_Tick,
    output logic             Hsync,
    output logic             Vsync,
    output logic             Display_En,
    output logic [CNT_W-1:0] Pix_X,
    output logic [CNT_W-1:0] Pix_Y,
    output logic             Line_Start,
    output logic             Frame_Start,
    output logic [7:0]       Frame_Count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = min_cnt_w(PIX_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic             H_ON     = (H_SYNC_POL != 0);
    localparam logic             V_ON     = (V_SYNC_POL != 0);

    generate
        if (H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
            PIX_DIV < 1 || CNT_W < 1 || CNT_W > 30 ||
            CNT_W < min_cnt_w(H_TOTAL) || CNT_W < min_cnt_w(V_TOTAL)) begin : g_bad_params
            $fatal(1, "vga_timing_gen: illegal timing parameter set");
        end
    endgenerate

    logic [DIV_W-1:0] div_q;
    logic             div_last;
    logic [CNT_W-1:0] h_count, v_count;
    logic             h_wrap, v_wrap, h_sync, v_sync, h_active, v_active;
    logic             line_q, frame_q;

    assign div_last = (div_q == DIV_LAST);

    // Gated by Reset so the tick is low while reset is held, even with PIX_DIV=1.
    assign Pix_Tick = Reset && Enable && div_last;

    vga_axis_counter #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .SYNC_POL(H_SYNC_POL),
        .CNT_W   (CNT_W)
    ) u_h_axis (
        .Clk   (Clk),
        .Reset (Reset),
        .step  (Pix_Tick),
        .count (h_count),
        .wrap  (h_wrap),
        .sync  (h_sync),
        .active(h_active)
    );

    // The vertical axis moves only on the tick that finishes a line.
    vga_axis_counter #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .SYNC_POL(V_SYNC_POL),
        .CNT_W   (CNT_W)
    ) u_v_axis (
        .Clk   (Clk),
        .Reset (Reset),
        .step  (h_wrap),
        .count (v_count),
        .wrap  (v_wrap),
        .sync  (v_sync),
        .active(v_active)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            div_q       <= '0;
            Pix_X       <= CNT_W'(H_TOTAL - 1);
            Pix_Y       <= CNT_W'(V_TOTAL - 1);
            Hsync       <= ~H_ON;
            Vsync       <= ~V_ON;
            Display_En  <= 1'b0;
            line_q      <= 1'b0;
            frame_q     <= 1'b0;
            Frame_Count <= 8'd0;
        end else begin
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            if (Enable) begin
                div_q <= div_last ? '0 : div_q + DIV_W'(1);
            end
            if (Pix_Tick) begin
                Pix_X      <= h_count;
                Pix_Y      <= v_count;
                Hsync      <= h_sync;
                Vsync      <= v_sync;
                Display_En <= h_active && v_active;
                // h wrapping means the new Pix_X is 0; both wrapping means (0, 0).
                line_q     <= h_wrap;
                frame_q    <= h_wrap && v_wrap;
                if (h_wrap && v_wrap) begin
                    Frame_Count <= Frame_Count + 8'd1;
                end
            end
        end
    end

    // Strobes are suppressed immediately while the generator is paused.
    assign Line_Start  = line_q && Enable;
    assign Frame_Start = frame_q && Enable;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a small raster

module tb_vga_timing_gen;

    localparam int HD = 8, HF = 2, HS = 3, HB = 1;
    localparam int VD = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b1;
    localparam int PIX_DIV = 2;
    localparam int CNT_W = 4;

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit de;
        bit ls;
        bit fs;
        int fc;
    } exp_t;

    typedef struct {
        int   cyc;
        exp_t e;
    } rec_t;

    logic             Clk;
    logic             Reset;
    logic             Enable;
    logic             Pix_Tick;
    logic             Hsync;
    logic             Vsync;
    logic             Display_En;
    logic [CNT_W-1:0] Pix_X;
    logic [CNT_W-1:0] Pix_Y;
    logic             Line_Start;
    logic             Frame_Start;
    logic [7:0]       Frame_Count;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n = 0;
    int   k = 0;
    bit   mon_on = 1'b0;
    rec_t q[$];

    vga_timing_gen #(
        .H_DISPLAY (HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY (VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(0), .V_SYNC_POL(1),
        .PIX_DIV   (PIX_DIV), .CNT_W(CNT_W)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Enable     (Enable),
        .Pix_Tick   (Pix_Tick),
        .Hsync      (Hsync),
        .Vsync      (Vsync),
        .Display_En (Display_En),
        .Pix_X      (Pix_X),
        .Pix_Y      (Pix_Y),
        .Line_Start (Line_Start),
        .Frame_Start(Frame_Start),
        .Frame_Count(Frame_Count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Raster state after the n-th pixel tick since reset (n = 0 is the reset state).
    function automatic exp_t predict(input int t);
        exp_t e;
        int   p;
        if (t == 0) begin
            e.x = HT - 1; e.y = VT - 1;
            e.hs = !HPOL; e.vs = !VPOL;
            e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.fc = 0;
            return e;
        end
        p    = (t - 1) % (HT * VT);
        e.x  = p % HT;
        e.y  = p / HT;
        e.hs = (e.x >= HD + HF && e.x < HD + HF + HS) ? HPOL : !HPOL;
        e.vs = (e.y >= VD + VF && e.y < VD + VF + VS) ? VPOL : !VPOL;
        e.de = (e.x < HD) && (e.y < VD);
        e.ls = (e.x == 0);
        e.fs = (p == 0);
        e.fc = ((t - 1) / (HT * VT) + 1) % 256;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_out(input string name, input exp_t e);
        chk({name, ".pix_x"},       int'(Pix_X),       e.x);
        chk({name, ".pix_y"},       int'(Pix_Y),       e.y);
        chk({name, ".hsync"},       int'(Hsync),       int'(e.hs));
        chk({name, ".vsync"},       int'(Vsync),       int'(e.vs));
        chk({name, ".display_en"},  int'(Display_En),  int'(e.de));
        chk({name, ".line_start"},  int'(Line_Start),  int'(e.ls));
        chk({name, ".frame_start"}, int'(Frame_Start), int'(e.fs));
        chk({name, ".frame_count"}, int'(Frame_Count), e.fc);
    endtask

    // Drive Enable for the coming edge and, if the model says that edge ends
    // a pixel period, queue the raster state it must produce.
    task automatic drive(input bit en);
        rec_t r;
        Enable = en;
        if (en) begin
            if (k % PIX_DIV == PIX_DIV - 1) begin
                n++;
                r.cyc = cyc;
                r.e   = predict(n);
                q.push_back(r);
            end
            k++;
        end
    endtask

    task automatic step(input bit en);
        @(negedge Clk);
        drive(en);
    endtask

    function automatic bit rnd_en();
        return ($urandom_range(15, 0) != 0);
    endfunction

    // Monitor: Pix_Tick is the valid; each tick pops one expected record and the
    // following edge's outputs are compared against it. Non-tick cycles must hold.
    initial begin
        exp_t last;
        exp_t pend;
        exp_t hold;
        rec_t r;
        bit   have_pend;
        bit   exp_tick;
        last      = predict(0);
        pend      = predict(0);
        have_pend = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (mon_on && Reset) begin
                if (have_pend) begin
                    check_out("tick", pend);
                    last = pend;
                end else begin
                    hold    = last;
                    hold.ls = 1'b0;
                    hold.fs = 1'b0;
                    check_out("hold", hold);
                end
            end
            have_pend = 1'b0;
            @(negedge Clk);
            #2;
            if (!mon_on) begin
                last = predict(0);
            end else begin
                while (q.size() != 0 && q[0].cyc < cyc) void'(q.pop_front());
                exp_tick = (q.size() != 0) && (q[0].cyc == cyc);
                chk("pix_tick", int'(Pix_Tick), int'(exp_tick));
                if (exp_tick) begin
                    r         = q.pop_front();
                    pend      = r.e;
                    have_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #900000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: got cycle %0d expected completion before it", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        Reset  = 1'b0;
        Enable = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        check_out("reset", predict(0));
        chk("reset.pix_tick", int'(Pix_Tick), 0);

        @(negedge Clk);
        Reset  = 1'b1;
        mon_on = 1'b1;
        drive(1'b1);

        // Run to Pix_X=6 on line 0, then pause for 5 clocks.
        while (n < 7) step(1'b1);
        repeat (5) step(1'b0);

        // Random run to (9, 2), then reset asynchronously mid-frame.
        while (n < 2 * HT + 10) step(rnd_en());
        @(negedge Clk);
        mon_on = 1'b0;
        Enable = 1'b1;
        #3;
        Reset = 1'b0;
        #1;
        check_out("async_reset", predict(0));
        chk("async_reset.pix_tick", int'(Pix_Tick), 0);
        repeat (2) @(negedge Clk);

        @(negedge Clk);
        Reset = 1'b1;
        n = 0;
        k = 0;
        q.delete();
        mon_on = 1'b1;
        drive(rnd_en());

        // Long random run across the Frame_Count 255 -> 0 wrap.
        while (n < 256 * HT * VT + 20) step(rnd_en());
        repeat (4) step(1'b0);
        chk("queue_empty", q.size(), 0);
        chk("final_frame_count", int'(Frame_Count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
